tiny_riscv_lsu: RTL
===================

Name: tiny_riscv_lsu

Overview:
- Load/store unit: the initiator side of the CPU data-memory port. It drives the registered-read, byte-masked-write memory block.
- Takes one load or store request from the core and issues one word access with the correct byte mask and lane-aligned write data.
- For loads, extracts the addressed byte or halfword from the returned word and zero- or sign-extends it.
- Sits between the execute stage and tiny_riscv_memory.

Parameters:
- MEM_BYTES, 6144: size of the addressable data memory. A byte address >= MEM_BYTES is an access fault.

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  LSU idle; request accepted when i_req_valid & o_req_ready at a rising edge
- i_req_is_store  in  1  1=store, 0=load
- i_req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- i_req_addr  in  32  byte address
- i_req_store_data  in  32  store source register, value in low bits
- o_resp_valid  out  1  one-cycle completion pulse
- o_resp_load_data  out  32  extended load result, valid with o_resp_valid on loads
- o_resp_err  out  1  misaligned, out-of-range or illegal funct3; valid with o_resp_valid
- o_mem_addr  out  32  byte address to memory
- o_read_strobe  out  1  memory read enable
- i_mem_data  in  32  memory read word, valid the cycle after the strobe is sampled
- o_mem_write_data  out  32  lane-replicated store data
- o_mem_write_mask  out  4  byte write enables

Behaviour:
- Reset (async, i_Rst=1):
  - state=IDLE; o_req_ready=1.
  - o_resp_valid=0, o_resp_err=0, o_read_strobe=0, o_mem_write_mask=0.
  - o_mem_addr=0, o_mem_write_data=0, o_resp_load_data=0.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered. o_req_ready=1 only in IDLE.
- IDLE, on accept:
  - Latch is_store, funct3, addr, store data.
  - Check for errors:
    - Illegal funct3: loads 011/11x; stores 011 or 1xx.
    - Misalignment: halfword with addr[0]=1; word with addr[1:0]!=0.
    - Range: addr >= MEM_BYTES.
  - Error present -> RESP with o_resp_err=1. No memory access ever occurs.
  - No error -> ISSUE.
- ISSUE, exactly one cycle:
  - o_mem_addr = latched address.
  - Load: o_read_strobe=1, mask=0.
  - Store: o_read_strobe=0. Mask and data by size:
    - SB: mask=4'b0001<<addr[1:0], data={4{d[7:0]}}.
    - SH: mask=4'b0011<<{addr[1],1'b0}, data={2{d[15:0]}}.
    - SW: mask=4'b1111, data=d.
  - Next state: load -> WAIT; store -> RESP.
- WAIT (loads only):
  - Sample i_mem_data.
  - Select the lane by addr[1:0] for a byte, or addr[1] for a halfword.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Register the result into o_resp_load_data. -> RESP.
- RESP:
  - o_resp_valid=1 for exactly one cycle. -> IDLE.
  - o_resp_load_data holds its value until the next load completes.
- Mask discipline: o_mem_write_mask must be 0 in every cycle except a store's ISSUE, because the memory writes whenever the mask is nonzero. o_read_strobe=1 only in a load's ISSUE.
- Latency from accept edge:
  - Load response: third cycle after accept.
  - Store response: second cycle after accept.
  - Error response: first cycle after accept.
  - Throughput: one request per 4/3/2 cycles.
- Request inputs are ignored outside IDLE; the core holds them until accepted.
- Reset mid-operation: returns to IDLE immediately and the mask drops asynchronously. A store in ISSUE may be partially lost; no response is produced.

Decomposition:
- Package tiny_riscv_pkg holds:
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State encoding localparams for IDLE/ISSUE/WAIT/RESP.
- Sub-module tiny_riscv_load_align: combinational (word, addr[1:0], funct3) -> extended 32-bit result. Used in WAIT; unit-testable alone.

Test Plan:
- Memory word at 0x400 = 0x04030201. LB 0x403 -> 0x00000004; LH 0x402 -> 0x00000403; LW 0x400 -> 0x04030201. Each has err=0 and resp_valid 3 cycles after accept.
- SB 0x40C, data 0x000000F0 -> ISSUE shows mask=4'b0001 and write_data=0xF0F0F0F0. Then LB 0x40C -> 0xFFFFFFF0, and LBU 0x40C -> 0x000000F0.
- SH 0x406, data 0x00008001 -> mask=4'b1100, write_data=0x80018001. Then LH 0x406 -> 0xFFFF8001, and LHU 0x406 -> 0x00008001.
- LW 0x402, SH 0x401, and LW 0x1800 (= MEM_BYTES) each -> err=1, resp_valid 1 cycle after accept. Read strobe and mask stay 0 throughout.
- Load funct3=3'b011 -> err=1, no memory access. Back-to-back valid requests -> ready low during ISSUE/WAIT/RESP, and the second request is accepted only in IDLE.
- Assert i_Rst during a store's ISSUE -> mask=0 and state=IDLE in the same cycle. No resp_valid is produced, and o_req_ready=1 after release.

Source files
------------

// File: rtl/tiny_riscv_pkg.sv
// Shared funct3 codes, FSM encoding, request record and decode helpers for the LSU.
// Pure declarations and combinational functions; no latency or backpressure of its own.
package tiny_riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } lsu_state_t;

    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
    } lsu_req_t;

    function automatic logic req_error(input logic        is_store,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] addr,
                                       input logic [31:0] limit);
        logic bad_f3;
        logic misal;
        if (is_store)
            bad_f3 = funct3[2] | (funct3[1:0] == 2'b11);
        else
            bad_f3 = (funct3[1:0] == 2'b11) | (funct3[2:1] == 2'b11);
        misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        return bad_f3 | misal | (addr >= limit);
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    return 4'b0001 << addr_lo;
            F3_H:    return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the source across lanes so the mask alone picks the bytes written.
    function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] d);
        case (funct3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/tiny_riscv_load_align.sv
// Picks the addressed byte/halfword out of a memory word and zero/sign-extends it.
// Purely combinational, zero latency, no flow control.
module tiny_riscv_load_align
    import tiny_riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/tiny_riscv_lsu.sv
// Load/store unit driving a registered-read, byte-masked-write data memory; all outputs registered.
// Latency load 3 / store 2 / error 1 cycles; o_req_ready only in IDLE, so one request in flight.
module tiny_riscv_lsu
    import tiny_riscv_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 6144
)(
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_is_store,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_store_data,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_load_data,
    output logic        o_resp_err,
    output logic [31:0] o_mem_addr,
    output logic        o_read_strobe,
    input  logic [31:0] i_mem_data,
    output logic [31:0] o_mem_write_data,
    output logic [3:0]  o_mem_write_mask
);

    lsu_state_t  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        strobe_q, strobe_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_q, load_d;
    logic [31:0] align_res;

    tiny_riscv_load_align u_align (
        .word    (i_mem_data),
        .addr_lo (req_q.addr[1:0]),
        .funct3  (req_q.funct3),
        .result  (align_res)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
            mask_q   <= 4'd0;
            wdata_q  <= 32'd0;
            load_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            load_q   <= load_d;
        end
    end

    // Outputs are registered, so ISSUE drive values are computed on the accept edge.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        ready_d  = 1'b0;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        strobe_d = 1'b0;
        mask_d   = 4'd0;
        wdata_d  = wdata_q;
        load_d   = load_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (i_req_valid) begin
                    req_d   = '{is_store: i_req_is_store, funct3: i_req_funct3, addr: i_req_addr};
                    ready_d = 1'b0;
                    if (req_error(i_req_is_store, i_req_funct3, i_req_addr, 32'(MEM_BYTES))) begin
                        state_d = RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = ISSUE;
                        strobe_d = !i_req_is_store;
                        if (i_req_is_store) begin
                            mask_d  = store_mask(i_req_funct3, i_req_addr[1:0]);
                            wdata_d = store_wdata(i_req_funct3, i_req_store_data);
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = req_q.is_store ? RESP : WAIT;
                valid_d = req_q.is_store;
            end
            WAIT: begin
                load_d  = align_res;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_req_ready      = ready_q;
    assign o_resp_valid     = valid_q;
    assign o_resp_err       = err_q;
    assign o_resp_load_data = load_q;
    assign o_mem_addr       = req_q.addr;
    assign o_read_strobe    = strobe_q;
    assign o_mem_write_mask = mask_q;
    assign o_mem_write_data = wdata_q;

endmodule
